famiclone_probe: RTL

Parametrised power-on console probe for the CoolGirl multicart, the generalised successor of the fixed new-famiclone detection in the top level. It holds the CIRAM /CE and /A13 lines grounded for a configurable number of M2 cycles after reset, then collects PPU address samples over a toggle handshake. It classifies the console as "new famiclone" when the A13 and /A13 pins disagree often enough, and reports a timeout when no decision is reached. Its outputs feed the `ppu_ciram_ce` and `ppu_not_a13_out` drivers in the top level.

---
 rtl/coolgirl_probe_pkg.sv | 14 +
 rtl/toggle_sync.sv | 17 +
 rtl/famiclone_probe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/coolgirl_probe_pkg.sv
// coolgirl_probe_pkg: shared state type, mismatch rule and default parameters for famiclone_probe
package coolgirl_probe_pkg;
   typedef enum logic [1:0] {ST_INIT, ST_SAMPLE, ST_DECIDE, ST_DONE} probe_state_e;
   localparam int DEF_INIT_CYCLES = 15;
   localparam int DEF_SAMPLES_LO = 3;
   localparam int DEF_SAMPLES_HI = 3;
   localparam int DEF_MISMATCH_MIN = 1;
   localparam int DEF_TIMEOUT_CYCLES = 65535;
   localparam int DEF_CNT_W = 4;
   // a genuine console drives /A13 as the inverse of A13
   function automatic logic is_mismatch(input logic a13, input logic not_a13);
      return a13 == not_a13;
   endfunction
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: 2-flop synchroniser for a toggle request plus pending compare against the local ack
module toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic ack_i,
   output logic req_s_o,
   output logic pending_o
);
   logic meta_q, sync_q;
   always_ff @(posedge clk) begin
      if (rst) {sync_q, meta_q} <= 2'b00;
      else {sync_q, meta_q} <= {meta_q, req_i};
   end
   assign req_s_o = sync_q;
   assign pending_o = sync_q != ack_i;
endmodule

// File: rtl/famiclone_probe.sv
// famiclone_probe: power-on CIRAM grounding and new-famiclone classification from A13 vs /A13 samples.
// Optional FAMICLONE_PROBE_RERUN_EN adds a probe_rerun input that restarts sampling from DONE.
module famiclone_probe
   import coolgirl_probe_pkg::*;
#(
   parameter int INIT_CYCLES = DEF_INIT_CYCLES,
   parameter int SAMPLES_LO = DEF_SAMPLES_LO,
   parameter int SAMPLES_HI = DEF_SAMPLES_HI,
   parameter int MISMATCH_MIN = DEF_MISMATCH_MIN,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             m2,
   input  logic             reset,
`ifdef FAMICLONE_PROBE_RERUN_EN
   input  logic             probe_rerun,
`endif
   input  logic             smp_req,
   input  logic             smp_a13,
   input  logic             smp_not_a13,
   output logic             smp_ack,
   output logic             init_ground,
   output logic             new_dendy,
   output logic             probe_done,
   output logic             probe_timeout,
   output logic [CNT_W-1:0] mismatch_cnt
);
   localparam int IW = $clog2(INIT_CYCLES + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam int LW = $clog2(SAMPLES_LO + 2);
   localparam int HW = $clog2(SAMPLES_HI + 2);
   probe_state_e state_q, state_d;
   logic [IW-1:0] init_q, init_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [LW-1:0] lo_q, lo_d;
   logic [HW-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] mis_q, mis_d;
   logic ack_q, ack_d, gnd_q, gnd_d, nd_q, nd_d, done_q, done_d, to_q, to_d;
   logic req_s, pending;
   toggle_sync u_sync (
      .clk(m2),
      .rst(reset),
      .req_i(smp_req),
      .ack_i(ack_q),
      .req_s_o(req_s),
      .pending_o(pending)
   );
   always_comb begin
      state_d = state_q;
      init_d = init_q;
      tcnt_d = tcnt_q;
      lo_d = lo_q;
      hi_d = hi_q;
      mis_d = mis_q;
      ack_d = pending ? req_s : ack_q;
      gnd_d = gnd_q;
      nd_d = nd_q;
      done_d = done_q;
      to_d = to_q;
      case (state_q)
         ST_INIT: begin
            init_d = init_q == '0 ? init_q : init_q - IW'(1);
            state_d = init_q == '0 ? ST_SAMPLE : ST_INIT;
            gnd_d = init_q != '0;
         end
         ST_SAMPLE: begin
            tcnt_d = tcnt_q + TW'(1);
            if (pending) begin
               mis_d = is_mismatch(smp_a13, smp_not_a13) && !(&mis_q) ? mis_q + CNT_W'(1) : mis_q;
               lo_d = smp_a13 ? lo_q : lo_q + LW'(1);
               hi_d = smp_a13 ? hi_q + HW'(1) : hi_q;
            end
            // a closing sample on the timeout cycle takes priority over the timeout
            if (pending && (lo_d == LW'(SAMPLES_LO) || hi_d == HW'(SAMPLES_HI))) state_d = ST_DECIDE;
            else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_DECIDE;
               to_d = 1'b1;
            end
         end
         ST_DECIDE: begin
            nd_d = !to_q && int'(mis_q) >= MISMATCH_MIN;
            done_d = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
`ifdef FAMICLONE_PROBE_RERUN_EN
            if (probe_rerun) begin
               state_d = ST_SAMPLE;
               tcnt_d = '0;
               lo_d = '0;
               hi_d = '0;
               mis_d = '0;
               nd_d = 1'b0;
               done_d = 1'b0;
               to_d = 1'b0;
            end
`endif
         end
      endcase
   end
   always_ff @(posedge m2) begin
      if (reset) begin
         state_q <= ST_INIT;
         init_q <= IW'(INIT_CYCLES);
         tcnt_q <= '0;
         lo_q <= '0;
         hi_q <= '0;
         mis_q <= '0;
         ack_q <= 1'b0;
         gnd_q <= 1'b1;
         nd_q <= 1'b0;
         done_q <= 1'b0;
         to_q <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q <= init_d;
         tcnt_q <= tcnt_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
         mis_q <= mis_d;
         ack_q <= ack_d;
         gnd_q <= gnd_d;
         nd_q <= nd_d;
         done_q <= done_d;
         to_q <= to_d;
      end
   end
   assign smp_ack = ack_q;
   assign init_ground = gnd_q;
   assign new_dendy = nd_q;
   assign probe_done = done_q;
   assign probe_timeout = to_q;
   assign mismatch_cnt = mis_q;
endmodule
